// File: rtl/lrsc_mem_arbiter_pkg.sv
// rtl/lrsc_mem_arbiter_pkg.sv - shared types for the dual-core LR/SC memory arbiter
package lrsc_mem_arbiter_pkg;

    localparam int WORD_W   = 32;
    localparam int RESV_LSB = 2;
    localparam int TAG_W    = WORD_W - RESV_LSB;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [TAG_W-1:0]  tag_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // S_ prefix keeps these apart from the ramstate_t labels in the same scope
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } resv_t;

    function automatic tag_t word_tag(input word_t addr);
        return addr[WORD_W-1:RESV_LSB];
    endfunction

endpackage

// File: rtl/lrsc_mem_arbiter_resv.sv
// rtl/lrsc_mem_arbiter_resv.sv - one core's LR reservation with set/clear/compare
module lrsc_resv_reg
    import lrsc_mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clr,
    input  tag_t tag_in,
    input  tag_t cmp_tag,
    output logic match
);

    resv_t resv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv <= '0;
        end else if (set) begin
            resv <= resv_t'{valid: 1'b1, tag: tag_in};
        end else if (clr) begin
            resv.valid <= 1'b0;
        end
    end

    assign match = resv.valid && (resv.tag == cmp_tag);

endmodule

// File: rtl/lrsc_mem_arbiter.sv
// rtl/lrsc_mem_arbiter.sv - two-core data-memory arbiter with LR/SC reservation tracking
module lrsc_mem_arbiter
    import lrsc_mem_arbiter_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic [1:0] dREN,
    input  logic [1:0] dWEN,
    input  logic [1:0] datomic,
    input  word_t      daddr [2],
    input  word_t      dstore [2],
    output logic [1:0] dhit,
    output word_t      dload [2],
    output logic       ramREN,
    output logic       ramWEN,
    output word_t      ramaddr,
    output word_t      ramstore,
    input  word_t      ramload,
    input  ramstate_t  ramstate
);

    arb_state_t state, state_next;
    logic       last_grant, grant_q, wr_q, atomic_q;
    word_t      addr_q, data_q;
    word_t      load_q [2];
    logic [1:0] req, resv_match, resv_set, resv_clr;
    logic       gnt_next, sc_fail, ram_done, grant_now;
    tag_t       cmp_tag, addr_tag;

    assign req       = dREN | dWEN;
    assign gnt_next  = (req == 2'b11) ? ~last_grant : req[1];
    assign grant_now = (state == S_IDLE) && (req != 2'b00);
    assign sc_fail   = dWEN[gnt_next] & datomic[gnt_next] & ~resv_match[gnt_next];
    assign ram_done  = (state == S_ACCESS) && (ramstate == ACCESS);
    assign addr_tag  = word_tag(addr_q);
    // In IDLE the compare port checks the incoming SC; otherwise it snoops the latched write
    assign cmp_tag   = (state == S_IDLE) ? word_tag(daddr[gnt_next]) : addr_tag;

    for (genvar c = 0; c < 2; c++) begin : g_resv
        assign resv_set[c] = ram_done && !wr_q && atomic_q && (grant_q == 1'(c));
        assign resv_clr[c] = (grant_now && sc_fail && (gnt_next == 1'(c)))
                           || (ram_done && wr_q && ((atomic_q && (grant_q == 1'(c))) || resv_match[c]));

        lrsc_resv_reg u_resv (
            .clk     (CLK),
            .rst_n   (nRST),
            .set     (resv_set[c]),
            .clr     (resv_clr[c]),
            .tag_in  (addr_tag),
            .cmp_tag (cmp_tag),
            .match   (resv_match[c])
        );
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (grant_now) state_next = sc_fail ? S_RESP : S_ACCESS;
            S_ACCESS: if (ramstate == ACCESS) state_next = S_RESP;
            S_RESP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        dhit     = 2'b00;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            S_ACCESS: begin
                ramREN   = !wr_q;
                ramWEN   = wr_q;
                ramaddr  = addr_q;
                ramstore = wr_q ? data_q : '0;
            end
            S_RESP:   dhit[grant_q] = 1'b1;
            default:  ;
        endcase
        for (int c = 0; c < 2; c++) begin
            dload[c] = load_q[c];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            wr_q       <= 1'b0;
            atomic_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            load_q[0]  <= '0;
            load_q[1]  <= '0;
        end else begin
            if (grant_now) begin
                last_grant <= gnt_next;
                grant_q    <= gnt_next;
                wr_q       <= dWEN[gnt_next];
                atomic_q   <= datomic[gnt_next];
                addr_q     <= daddr[gnt_next];
                data_q     <= dstore[gnt_next];
                if (sc_fail) load_q[gnt_next] <= word_t'(1);
            end
            // Stores and successful SCs report 0; reads return the RAM word
            if (ram_done) load_q[grant_q] <= wr_q ? '0 : ramload;
        end
    end

endmodule

// File: tb/tb_lrsc_mem_arbiter.sv
// tb/tb_lrsc_mem_arbiter.sv - randomized and directed checks of lrsc_mem_arbiter against a transaction model
module tb_lrsc_mem_arbiter;
    import lrsc_mem_arbiter_pkg::*;

    localparam int OP_LW = 0, OP_SW = 1, OP_LR = 2, OP_SC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nRST;
    logic [1:0] dREN, dWEN, datomic, dhit;
    word_t      daddr [2], dstore [2], dload [2];
    logic       ramREN, ramWEN;
    word_t      ramaddr, ramstore, ramload;
    ramstate_t  ramstate;

    lrsc_mem_arbiter dut (
        .CLK(clk), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .datomic(datomic),
        .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    int n_chk = 0, n_fail = 0, cyc = 0, wr_count = 0, ram_mode = 1;
    word_t ram_mem [256];
    assign ramload = ram_mem[ramaddr[9:2]];

    int    cmd_op [2], cmd_seq [2], taken_seq [2], done_seq [2];
    word_t cmd_addr [2], cmd_data [2];
    bit    cmd_both [2], cl_act [2];
    word_t hit_val [2];
    int    hit_cyc [2], req_cyc [2];

    // transaction model
    bit    m_on, m_wr, m_at, m_ram, m_done;
    int    m_core, m_acc, m_hit, m_lg;
    word_t m_addr, m_data;
    bit    m_rv [2];
    word_t m_rw [2], m_last [2];
    word_t m_mem [256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic issue(input int c, input int op, input word_t a, input word_t d, input bit both = 1'b0);
        cmd_op[c] = op; cmd_addr[c] = a; cmd_data[c] = d; cmd_both[c] = both;
        cmd_seq[c]++;
    endtask

    task automatic wait_done(input int c);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); #1;
            ok = (done_seq[c] == cmd_seq[c]);
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL wait_core%0d: no dhit within 100 cycles, required one", c);
        end
    endtask

    // monitor: compare outputs, react as clients and RAM, advance the model
    initial begin
        bit [1:0] rq, exp_hit;
        bit       in_acc;
        int       strobe_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 32'hA500_0000 + i;
            m_mem[i]   = 32'hA500_0000 + i;
        end
        for (int c = 0; c < 2; c++) begin
            cmd_seq[c] = 0; taken_seq[c] = 0; done_seq[c] = 0; cl_act[c] = 0;
            daddr[c] = '0; dstore[c] = '0;
        end
        dREN = '0; dWEN = '0; datomic = '0; ramstate = FREE;
        forever begin
            @(negedge clk);
            cyc++;
            if (!nRST) begin
                m_on = 0; m_lg = 1; m_hit = -1;
                for (int c = 0; c < 2; c++) begin
                    m_rv[c] = 0; m_last[c] = '0; cl_act[c] = 0;
                    taken_seq[c] = cmd_seq[c]; done_seq[c] = cmd_seq[c];
                    daddr[c] = '0; dstore[c] = '0;
                end
                dREN = '0; dWEN = '0; datomic = '0; ramstate = FREE; strobe_cnt = 0;
            end
            exp_hit = (m_on && cyc == m_hit) ? (2'b01 << m_core) : 2'b00;
            in_acc  = m_on && m_ram && !m_done && cyc >= m_acc;
            chk("dhit", dhit, exp_hit);
            chk("ramREN", ramREN, in_acc && !m_wr);
            chk("ramWEN", ramWEN, in_acc && m_wr);
            chk("ramaddr", ramaddr, in_acc ? m_addr : 0);
            chk("ramstore", ramstore, (in_acc && m_wr) ? m_data : 0);
            chk("dload0", dload[0], m_last[0]);
            chk("dload1", dload[1], m_last[1]);
            if (nRST) begin
                for (int c = 0; c < 2; c++) begin
                    if (cl_act[c] && dhit[c]) begin
                        hit_val[c] = dload[c]; hit_cyc[c] = cyc;
                        done_seq[c] = taken_seq[c]; cl_act[c] = 0;
                    end
                    if (!cl_act[c] && taken_seq[c] != cmd_seq[c]) begin
                        taken_seq[c] = cmd_seq[c]; cl_act[c] = 1; req_cyc[c] = cyc;
                    end
                    dWEN[c]    = cl_act[c] && (cmd_op[c] == OP_SW || cmd_op[c] == OP_SC);
                    dREN[c]    = cl_act[c] && (cmd_op[c] == OP_LW || cmd_op[c] == OP_LR || (cmd_both[c] && dWEN[c]));
                    datomic[c] = cl_act[c] && (cmd_op[c] >= OP_LR);
                    daddr[c]   = cl_act[c] ? cmd_addr[c] : '0;
                    dstore[c]  = cl_act[c] ? cmd_data[c] : '0;
                end
                if (ramREN || ramWEN) strobe_cnt++; else strobe_cnt = 0;
                case (ram_mode)
                    1: ramstate = (strobe_cnt == 2) ? ACCESS : BUSY;
                    2: ramstate = BUSY;
                    default: case ($urandom % 5)
                        0, 1: ramstate = ACCESS;
                        2: ramstate = BUSY;
                        3: ramstate = FREE;
                        default: ramstate = ERROR;
                    endcase
                endcase
                if (ramWEN && ramstate == ACCESS) begin
                    ram_mem[ramaddr[9:2]] = ramstore; wr_count++;
                end
                if (m_on) begin
                    if (cyc == m_hit) begin
                        m_on = 0;
                    end else if (m_ram && !m_done && cyc >= m_acc && ramstate == ACCESS) begin
                        m_done = 1; m_hit = cyc + 1;
                        if (m_wr) begin
                            m_mem[m_addr[9:2]] = m_data;
                            for (int k = 0; k < 2; k++)
                                if (m_rv[k] && m_rw[k] == (m_addr >> 2)) m_rv[k] = 0;
                            if (m_at) m_rv[m_core] = 0;
                            m_last[m_core] = '0;
                        end else begin
                            m_last[m_core] = m_mem[m_addr[9:2]];
                            if (m_at) begin m_rv[m_core] = 1; m_rw[m_core] = m_addr >> 2; end
                        end
                    end
                end else begin
                    rq = dREN | dWEN;
                    if (rq != 2'b00) begin
                        m_core = (rq == 2'b11) ? 1 - m_lg : (rq[1] ? 1 : 0);
                        m_lg = m_core; m_on = 1;
                        m_wr = dWEN[m_core]; m_at = datomic[m_core];
                        m_addr = daddr[m_core]; m_data = dstore[m_core];
                        if (m_wr && m_at && !(m_rv[m_core] && m_rw[m_core] == (m_addr >> 2))) begin
                            m_rv[m_core] = 0; m_last[m_core] = 32'd1;
                            m_ram = 0; m_hit = cyc + 1;
                        end else begin
                            m_ram = 1; m_done = 0; m_acc = cyc + 1; m_hit = -1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int    wc, pend [2];
        bit    seen;
        word_t a;
        nRST = 1'b0;
        repeat (3) @(negedge clk);
        #2 nRST = 1'b1;

        // tie: core0 first, core1 one full transaction later
        @(negedge clk); #1;
        issue(0, OP_LW, 32'h100, 0); issue(1, OP_LW, 32'h200, 0);
        wait_done(0); wait_done(1);
        chk("tie_val0", hit_val[0], 32'hA500_0040);
        chk("tie_val1", hit_val[1], 32'hA500_0080);
        chk("tie_order", hit_cyc[1] - hit_cyc[0], 4);

        // LR/SC success, then a second SC finds the reservation gone
        issue(0, OP_LR, 32'h40, 0); wait_done(0);
        chk("lr_val", hit_val[0], 32'hA500_0010);
        wc = wr_count;
        issue(0, OP_SC, 32'h40, 32'hAA, 1'b1); wait_done(0);
        chk("sc_ok", hit_val[0], 0);
        chk("sc_ok_writes", wr_count - wc, 1);
        chk("sc_ok_mem", ram_mem[16], 32'hAA);
        issue(0, OP_SC, 32'h40, 32'hBB); wait_done(0);
        chk("sc_again_fail", hit_val[0], 1);
        chk("sc_again_writes", wr_count - wc, 1);

        // another core's store to the same word kills the reservation
        issue(0, OP_LR, 32'h40, 0); wait_done(0);
        chk("lr_val2", hit_val[0], 32'hAA);
        issue(1, OP_SW, 32'h42, 32'h55); wait_done(1);
        chk("sw_ack", hit_val[1], 0);
        wc = wr_count;
        issue(0, OP_SC, 32'h40, 32'h77); wait_done(0);
        chk("inval_fail", hit_val[0], 1);
        chk("inval_writes", wr_count - wc, 0);

        // SC with no reservation answers without touching RAM
        wc = wr_count;
        issue(1, OP_SC, 32'h80, 32'h99); wait_done(1);
        chk("noresv_fail", hit_val[1], 1);
        chk("noresv_latency", hit_cyc[1] - req_cyc[1], 1);
        chk("noresv_writes", wr_count - wc, 0);

        // same-word SC race
        issue(0, OP_LR, 32'h40, 0); wait_done(0);
        issue(1, OP_LR, 32'h41, 0); wait_done(1);
        chk("race_lr1", hit_val[1], 32'h55);
        wc = wr_count;
        issue(0, OP_SC, 32'h40, 32'h11); issue(1, OP_SC, 32'h43, 32'h22);
        wait_done(0); wait_done(1);
        chk("race_win", hit_val[0], 0);
        chk("race_lose", hit_val[1], 1);
        chk("race_writes", wr_count - wc, 1);
        chk("race_mem", ram_mem[16], 32'h11);

        // async reset while a read is stalled in the RAM
        issue(0, OP_LR, 32'h40, 0); wait_done(0);
        issue(1, OP_LR, 32'h80, 0); wait_done(1);
        ram_mode = 2;
        issue(0, OP_LW, 32'h100, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            seen = ramREN;
        end
        chk("rst_reached_access", seen, 1);
        #1 nRST = 1'b0;
        #1;
        chk("rst_ramREN", ramREN, 0);
        chk("rst_dhit", dhit, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_dload0", dload[0], 0);
        @(negedge clk); @(negedge clk);
        ram_mode = 1;
        #2 nRST = 1'b1;
        issue(0, OP_SC, 32'h40, 32'h1); wait_done(0);
        chk("rst_resv0", hit_val[0], 1);
        issue(1, OP_SC, 32'h80, 32'h2); wait_done(1);
        chk("rst_resv1", hit_val[1], 1);

        // random traffic checked cycle-by-cycle by the monitor
        ram_mode = 0;
        pend[0] = 0; pend[1] = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk); #1;
            for (int c = 0; c < 2; c++) begin
                if (done_seq[c] == cmd_seq[c]) begin
                    pend[c] = 0;
                    if ($urandom % 2 == 0) begin
                        case ($urandom % 4)
                            0: a = 32'h40;
                            1: a = 32'h44;
                            2: a = 32'h80;
                            default: a = 32'h100;
                        endcase
                        a = a + ($urandom % 4);
                        case ($urandom % 10)
                            0, 1, 2: issue(c, OP_LW, a, $urandom);
                            3, 4:    issue(c, OP_SW, a, $urandom, 1'($urandom));
                            5, 6, 7: issue(c, OP_LR, a, $urandom);
                            default: issue(c, OP_SC, a, $urandom, 1'($urandom));
                        endcase
                    end
                end else if (++pend[c] == 300) begin
                    n_chk++; n_fail++;
                    $display("FAIL random_core%0d: no dhit within 300 cycles, required one", c);
                end
            end
        end
        wait_done(0); wait_done(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
